paddle_ctrl_multi: RTL and testbench

Parametrised multi-channel paddle controller. It is the successor to the single-paddle up/down counter.
- Per channel: synchronises and debounces up/down buttons, and advances a clamped (saturating) vertical position on an internal move tick.
- Optional acceleration: step size grows while a direction is held.
- Global recenter command.
- Sits between the board push-buttons and the VGA renderer / ball-collision logic, which consume the flattened coordinate bus.

---
 rtl/paddle_ctrl_multi.sv | 200 ++++++++++++++++++++
 tb/tb_paddle_ctrl_multi.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/paddle_ctrl_multi.sv
`default_nettype none
// ============================================================================
// Module   : paddle_ctrl_multi
// Purpose  : N-channel paddle controller. Debounced buttons drive saturating
//            positions on a shared move tick, with optional acceleration.
// Revision : 1.0 - initial release
// ============================================================================
module paddle_ctrl_multi #(
  parameter int N           = 2,
  parameter int W           = 9,
  parameter int SCREEN_H    = 480,
  parameter int PAD_H       = 100,
  parameter int TICK_DIV    = 100000,
  parameter int DEB_CYCLES  = 4,
  parameter int ACCEL_EN    = 1,
  parameter int STEP_MIN    = 1,
  parameter int STEP_MAX    = 4,
  parameter int ACCEL_TICKS = 8
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           enable,
  input  logic           recenter,
  input  logic [N-1:0]   btn_up,
  input  logic [N-1:0]   btn_down,
  output logic [N*W-1:0] coord,
  output logic [N-1:0]   at_top,
  output logic [N-1:0]   at_bottom,
  output logic           move_tick
);

  localparam int MAXPOS = SCREEN_H - PAD_H;
  localparam int CENTER = MAXPOS / 2;
  localparam int TW     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int DW     = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
  localparam int SW     = $clog2(STEP_MAX + 1);
  localparam int HW     = (ACCEL_TICKS > 1) ? $clog2(ACCEL_TICKS) : 1;
  localparam logic [W:0] MAXPOS_X = (W+1)'(MAXPOS);

  typedef enum logic [1:0] {
    DIR_IDLE = 2'd0,
    DIR_UP   = 2'd1,
    DIR_DOWN = 2'd2
  } dir_e;

  // Up buttons occupy the low N bits, down buttons the high N bits.
  logic [2*N-1:0] raw;
  logic [2*N-1:0] sync1_q, sync1_d, sync2_q, sync2_d;
  logic [2*N-1:0] deb;

  assign raw = {btn_down, btn_up};

  always_comb begin
    sync1_d = raw;
    sync2_d = sync1_q;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
    end
  end

  for (genvar b = 0; b < 2*N; b++) begin : g_deb
    logic          lvl_q, lvl_d;
    logic [DW-1:0] cnt_q, cnt_d;

    always_comb begin
      lvl_d = lvl_q;
      cnt_d = '0;
      if (sync2_q[b] != lvl_q) begin
        if (cnt_q == DW'(DEB_CYCLES - 1)) lvl_d = sync2_q[b];
        else                              cnt_d = cnt_q + DW'(1);
      end
    end

    always_ff @(posedge clk) begin
      if (!reset) begin
        lvl_q <= 1'b0;
        cnt_q <= '0;
      end else begin
        lvl_q <= lvl_d;
        cnt_q <= cnt_d;
      end
    end

    assign deb[b] = lvl_q;
  end

  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic          move_tick_q, move_tick_d;

  always_comb begin
    move_tick_d = (tick_cnt_q == TW'(TICK_DIV - 1));
    tick_cnt_d  = move_tick_d ? '0 : tick_cnt_q + TW'(1);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      tick_cnt_q  <= '0;
      move_tick_q <= 1'b0;
    end else begin
      tick_cnt_q  <= tick_cnt_d;
      move_tick_q <= move_tick_d;
    end
  end

  assign move_tick = move_tick_q;

  for (genvar i = 0; i < N; i++) begin : g_ch
    logic [W-1:0]  coord_q, coord_d;
    logic [SW-1:0] step;
    logic [W:0]    cur, step_x, sum;
    dir_e          dir;

    always_comb begin
      dir = DIR_IDLE;
      if (deb[i] && !deb[N+i])      dir = DIR_UP;
      else if (deb[N+i] && !deb[i]) dir = DIR_DOWN;
    end

    // One spare bit keeps both the clamp compare and the subtract wrap-free.
    always_comb begin
      cur     = {1'b0, coord_q};
      step_x  = (W+1)'(step);
      sum     = cur + step_x;
      coord_d = coord_q;
      if (recenter) begin
        coord_d = W'(CENTER);
      end else if (move_tick_q && enable) begin
        case (dir)
          DIR_UP:   coord_d = (sum > MAXPOS_X) ? W'(MAXPOS) : sum[W-1:0];
          DIR_DOWN: coord_d = (cur >= step_x) ? (coord_q - step_x[W-1:0]) : '0;
          default:  coord_d = coord_q;
        endcase
      end
    end

    always_ff @(posedge clk) begin
      if (!reset) coord_q <= W'(CENTER);
      else        coord_q <= coord_d;
    end

    if (ACCEL_EN != 0) begin : g_accel
      logic [SW-1:0] step_q, step_d;
      logic [HW-1:0] hold_q, hold_d;
      dir_e          last_dir_q, last_dir_d;

      always_comb begin
        step_d     = step_q;
        hold_d     = hold_q;
        last_dir_d = last_dir_q;
        if (recenter || (move_tick_q && !enable)) begin
          step_d     = SW'(STEP_MIN);
          hold_d     = '0;
          last_dir_d = DIR_IDLE;
        end else if (move_tick_q) begin
          last_dir_d = dir;
          if ((dir == last_dir_q) && (dir != DIR_IDLE)) begin
            if (hold_q == HW'(ACCEL_TICKS - 1)) begin
              hold_d = '0;
              if (step_q < SW'(STEP_MAX)) step_d = step_q + SW'(1);
            end else begin
              hold_d = hold_q + HW'(1);
            end
          end else begin
            step_d = SW'(STEP_MIN);
            hold_d = '0;
          end
        end
      end

      always_ff @(posedge clk) begin
        if (!reset) begin
          step_q     <= SW'(STEP_MIN);
          hold_q     <= '0;
          last_dir_q <= DIR_IDLE;
        end else begin
          step_q     <= step_d;
          hold_q     <= hold_d;
          last_dir_q <= last_dir_d;
        end
      end

      assign step = step_q;
    end else begin : g_fixed
      assign step = SW'(STEP_MIN);
    end

    assign coord[i*W +: W] = coord_q;
    assign at_top[i]       = (coord_q == W'(MAXPOS));
    assign at_bottom[i]    = (coord_q == '0);
  end

endmodule
`default_nettype wire

// File: tb/tb_paddle_ctrl_multi.sv
`default_nettype none
// Bench for paddle_ctrl_multi: vector table, directed corner sequences and
// randomised traffic, all checked against a rule-level reference model.
module tb_paddle_ctrl_multi;

  localparam int N        = 2;
  localparam int W        = 9;
  localparam int TICK_DIV = 4;
  localparam int DEB      = 3;
  localparam int SMIN     = 1;
  localparam int SMAX     = 4;
  localparam int AT       = 2;
  localparam int MAXPOS   = 380;
  localparam int CENTER   = 190;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         enable = 1'b1;
  logic         recenter = 1'b0;
  logic [N-1:0] btn_up = '0;
  logic [N-1:0] btn_down = '0;
  logic [N*W-1:0] coord;
  logic [N-1:0] at_top, at_bottom;
  logic         move_tick;

  always #5 clk = ~clk;

  paddle_ctrl_multi #(
    .N(N), .W(W), .SCREEN_H(480), .PAD_H(100), .TICK_DIV(TICK_DIV),
    .DEB_CYCLES(DEB), .ACCEL_EN(1), .STEP_MIN(SMIN), .STEP_MAX(SMAX),
    .ACCEL_TICKS(AT)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .recenter(recenter),
    .btn_up(btn_up), .btn_down(btn_down), .coord(coord),
    .at_top(at_top), .at_bottom(at_bottom), .move_tick(move_tick)
  );

  // Reference model: positions and acceleration from the movement rules,
  // debounce from a window over the logged raw button samples.
  int  edge_n = 0;
  int  rst_edge = 0;
  bit  model_on = 1'b0;
  int  m_pos[N], m_step[N], m_hold[N], m_last[N];
  int  m_lvl[2*N], m_flip[2*N];
  bit  raw_log[2*N][64];
  bit  m_tick = 1'b0;

  int  n_checks = 0;
  int  n_fail = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_n);
    end
  endtask

  function automatic int synced(input int b, input int k);
    if (k - 2 <= rst_edge) return 0;
    return int'(raw_log[b][(k-2) % 64]);
  endfunction

  function automatic int min2(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  task automatic model_edge();
    int dir;
    bit ok;
    edge_n++;
    if (!reset) begin
      rst_edge = edge_n;
      m_tick   = 1'b0;
      model_on = 1'b1;
      for (int c = 0; c < N; c++) begin
        m_pos[c] = CENTER; m_step[c] = SMIN; m_hold[c] = 0; m_last[c] = 0;
      end
      for (int b = 0; b < 2*N; b++) begin
        m_lvl[b] = 0; m_flip[b] = edge_n;
      end
      return;
    end
    for (int b = 0; b < 2*N; b++)
      raw_log[b][edge_n % 64] = (b < N) ? btn_up[b] : btn_down[b-N];
    for (int c = 0; c < N; c++) begin
      dir = (m_lvl[c] == 1 && m_lvl[N+c] == 0) ? 1 :
            (m_lvl[N+c] == 1 && m_lvl[c] == 0) ? 2 : 0;
      if (recenter) begin
        m_pos[c] = CENTER; m_step[c] = SMIN; m_hold[c] = 0; m_last[c] = 0;
      end else if (m_tick) begin
        if (!enable) begin
          m_step[c] = SMIN; m_hold[c] = 0; m_last[c] = 0;
        end else begin
          if (dir == 1) m_pos[c] = min2(m_pos[c] + m_step[c], MAXPOS);
          if (dir == 2) m_pos[c] = (m_pos[c] >= m_step[c]) ? m_pos[c] - m_step[c] : 0;
          if (dir != 0 && dir == m_last[c]) begin
            if (m_hold[c] == AT - 1) begin
              m_hold[c] = 0; m_step[c] = min2(m_step[c] + 1, SMAX);
            end else begin
              m_hold[c]++;
            end
          end else begin
            m_step[c] = SMIN; m_hold[c] = 0;
          end
          m_last[c] = dir;
        end
      end
    end
    for (int b = 0; b < 2*N; b++) begin
      ok = 1'b1;
      for (int j = 0; j < DEB; j++) begin
        if (edge_n - j <= m_flip[b]) ok = 1'b0;
        else if (synced(b, edge_n - j) == m_lvl[b]) ok = 1'b0;
      end
      if (ok) begin
        m_lvl[b] = 1 - m_lvl[b];
        m_flip[b] = edge_n;
      end
    end
    m_tick = ((edge_n - rst_edge) % TICK_DIV) == 0;
  endtask

  task automatic check_all();
    for (int c = 0; c < N; c++) begin
      chk($sformatf("coord%0d", c), int'(coord[c*W +: W]), m_pos[c]);
      chk($sformatf("at_top%0d", c), int'(at_top[c]), int'(m_pos[c] == MAXPOS));
      chk($sformatf("at_bottom%0d", c), int'(at_bottom[c]), int'(m_pos[c] == 0));
    end
    chk("move_tick", int'(move_tick), int'(m_tick));
  endtask

  task automatic cycle();
    @(posedge clk);
    model_edge();
    #1;
    if (model_on) check_all();
  endtask

  typedef struct {
    logic [N-1:0] up;
    logic [N-1:0] dn;
    logic         en;
    int           ticks;
    int           c0;
    int           c1;
    logic [N-1:0] top;
    logic [N-1:0] bot;
  } row_t;

  row_t rows[10];

  task automatic recenter_seq();
    cycle(); cycle();
    recenter = 1'b1;
    cycle();
    chk("recenter_c0", int'(coord[0 +: W]), CENTER);
    chk("recenter_c1", int'(coord[W +: W]), CENTER);
    recenter = 1'b0;
    cycle();
  endtask

  initial begin
    int k;
    int sel;

    // Inputs change right after a qualifying tick edge, so each newly pressed
    // direction is first seen one tick later (debounce > tick period).
    rows[0] = '{2'b01, 2'b00, 1'b1, 11, 215, 190, 2'b00, 2'b00};
    rows[1] = '{2'b00, 2'b00, 1'b1,  2, 219, 190, 2'b00, 2'b00};
    rows[2] = '{2'b01, 2'b00, 1'b1,  2, 220, 190, 2'b00, 2'b00};
    rows[3] = '{2'b00, 2'b00, 1'b1,  2, 221, 190, 2'b00, 2'b00};
    rows[4] = '{2'b10, 2'b10, 1'b1,  3, 221, 190, 2'b00, 2'b00};
    rows[5] = '{2'b00, 2'b10, 1'b1,  2, 221, 189, 2'b00, 2'b00};
    rows[6] = '{2'b01, 2'b10, 1'b0,  5, 221, 189, 2'b00, 2'b00};
    rows[7] = '{2'b01, 2'b10, 1'b1,  3, 224, 186, 2'b00, 2'b00};
    rows[8] = '{2'b01, 2'b10, 1'b1, 60, 380,   0, 2'b01, 2'b10};
    rows[9] = '{2'b01, 2'b10, 1'b1,  3, 380,   0, 2'b01, 2'b10};

    reset = 1'b0;
    repeat (3) cycle();
    chk("rst_coord0", int'(coord[0 +: W]), 190);
    chk("rst_coord1", int'(coord[W +: W]), 190);
    chk("rst_at_top", int'(at_top), 0);
    chk("rst_at_bottom", int'(at_bottom), 0);
    chk("rst_move_tick", int'(move_tick), 0);
    reset = 1'b1;

    k = 0;
    while (move_tick !== 1'b1 && k < 20) begin cycle(); k++; end
    chk("first_tick_seen", int'(move_tick === 1'b1), 1);
    k = 0;
    do begin cycle(); k++; end while (move_tick !== 1'b1 && k < 20);
    chk("tick_period", k, TICK_DIV);
    cycle();

    // A 2-clk glitch on down must never reach the debounced level.
    btn_down[1] = 1'b1;
    cycle(); cycle();
    btn_down[1] = 1'b0;
    cycle(); cycle();
    repeat (2*TICK_DIV) cycle();
    chk("glitch_c1", int'(coord[W +: W]), 190);
    chk("idle_c0", int'(coord[0 +: W]), 190);

    for (int r = 0; r < 10; r++) begin
      if (r == 8) recenter_seq();
      btn_up   = rows[r].up;
      btn_down = rows[r].dn;
      enable   = rows[r].en;
      repeat (rows[r].ticks * TICK_DIV) cycle();
      chk($sformatf("row%0d_c0", r), int'(coord[0 +: W]), rows[r].c0);
      chk($sformatf("row%0d_c1", r), int'(coord[W +: W]), rows[r].c1);
      chk($sformatf("row%0d_top", r), int'(at_top), int'(rows[r].top));
      chk($sformatf("row%0d_bot", r), int'(at_bottom), int'(rows[r].bot));
    end

    // Reset while channel 0 is accelerating at step 3.
    recenter = 1'b1;
    cycle();
    recenter = 1'b0;
    k = 0;
    while (m_step[0] != 3 && k < 200) begin cycle(); k++; end
    chk("reach_step3", int'(m_step[0] == 3), 1);
    reset = 1'b0;
    cycle();
    chk("midrst_c0", int'(coord[0 +: W]), 190);
    chk("midrst_c1", int'(coord[W +: W]), 190);
    reset = 1'b1;
    k = 0;
    while (coord[0 +: W] == 9'd190 && k < 40) begin cycle(); k++; end
    chk("post_rst_first_step", int'(coord[0 +: W]) - 190, 1);

    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(7) == 0) begin
        sel = $urandom_range(N-1);
        btn_up[sel] = ~btn_up[sel];
      end
      if ($urandom_range(7) == 0) begin
        sel = $urandom_range(N-1);
        btn_down[sel] = ~btn_down[sel];
      end
      if ($urandom_range(63) == 0) enable = ~enable;
      recenter = ($urandom_range(199) == 0);
      reset    = ($urandom_range(499) != 0);
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation still running at %0t, expected to have finished", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
